// File: rtl/fir_out_checker.sv
// fir_out_checker
//   Receive-side checker for the FIR bench datapath. It watches the stimulus
//   stream that feeds the FIR under test and computes a bit-exact 5-tap golden
//   output for every sample. Each golden value is queued. DUT outputs are then
//   compared against the queue in arrival order. Mismatches, queue
//   overflow/underflow and output stalls are reported. A final DONE/PASS
//   verdict is raised once END_SIM has been seen and the queue has drained.
// Ports
//   CLK, RST            clock; synchronous active-high reset
//   VIN_SRC, DIN_SRC    stimulus valid / sample (same nets that feed the FIR)
//   B0..B4              coefficients, static after reset release
//   VOUT_DUT, DOUT_DUT  DUT output valid / sample
//   END_SIM             stimulus finished (level)
//   ERR                 one-cycle pulse after a mismatching compare
//   ERR_CNT, MATCH_CNT  saturating mismatch / match counters
//   OVF, UNF, STALL     sticky overflow / underflow / stall flags
//   DONE, PASS          drain complete / clean verdict
module fir_out_checker #(
  parameter int NB         = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          VIN_SRC,
  input  logic [NB-1:0] DIN_SRC,
  input  logic [NB-1:0] B0,
  input  logic [NB-1:0] B1,
  input  logic [NB-1:0] B2,
  input  logic [NB-1:0] B3,
  input  logic [NB-1:0] B4,
  input  logic          VOUT_DUT,
  input  logic [NB-1:0] DOUT_DUT,
  input  logic          END_SIM,
  output logic          ERR,
  output logic [15:0]   ERR_CNT,
  output logic [15:0]   MATCH_CNT,
  output logic          OVF,
  output logic          UNF,
  output logic          STALL,
  output logic          DONE,
  output logic          PASS
);
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = AW + 1;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int PW   = 2 * NB;
  localparam int ACCW = 2 * NB + 3;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Full-precision signed product, sign-extended to the accumulator width.
  function automatic logic signed [ACCW-1:0] mul_ext(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;
    logic signed [PW-1:0] p;
    ae = {{NB{a[NB-1]}}, a};
    be = {{NB{b[NB-1]}}, b};
    p  = ae * be;
    return $signed({{(ACCW-PW){p[PW-1]}}, p});
  endfunction

  // State. tap[k] holds the sample that becomes x(k+1) when the next one arrives.
  logic [NB-1:0] tap [4];
  logic          push_valid;
  logic [NB-1:0] push_data;
  logic [NB-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic [1:0]    state;

  // Next-state and datapath signals.
  logic signed [ACCW-1:0] acc;
  logic          acc_unused;
  logic [NB-1:0] y;
  logic          active, vin, vout, pushing, empty, full;
  logic          bypass, pop, cmp_en, mismatch, matched, wr_en, drop, exit_drain;
  logic [NB-1:0] cmp_val;
  logic [NB-1:0] tap_n [4];
  logic          push_valid_n;
  logic [NB-1:0] push_data_n;
  logic [AW-1:0] wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] count_n;
  logic [TW-1:0] timer_n;
  logic [1:0]    state_n;
  logic [15:0]   err_cnt_n, match_cnt_n;
  logic          err_n, ovf_n, unf_n, stall_n, done_n, pass_n;

  // Golden model, queue control, compare, stall timer and verdict FSM.
  always_comb begin
    acc = mul_ext(B0, DIN_SRC) + mul_ext(B1, tap[0]) + mul_ext(B2, tap[1])
        + mul_ext(B3, tap[2]) + mul_ext(B4, tap[3]);
    // Truncate and wrap: keep acc[2NB-2:NB-1], drop the rest.
    y          = acc[2*NB-2:NB-1];
    acc_unused = ^{acc[ACCW-1:2*NB-1], acc[NB-2:0]};

    // Once DONE is reached every input is ignored and all state freezes.
    active   = (state != ST_DONE);
    vin      = VIN_SRC & active;
    vout     = VOUT_DUT & active;
    pushing  = push_valid & active;
    empty    = (count == {CW{1'b0}});
    full     = (count == CNT_FULL);

    // An empty queue with a value arriving this cycle compares against that
    // value directly; it is never stored.
    bypass   = vout & empty & pushing;
    pop      = vout & ~empty;
    cmp_en   = pop | bypass;
    cmp_val  = pop ? mem[rd_ptr] : push_data;
    mismatch = cmp_en & (DOUT_DUT != cmp_val);
    matched  = cmp_en & (DOUT_DUT == cmp_val);
    // A full queue still accepts a push when a pop frees the head slot.
    wr_en    = pushing & ~bypass & (~full | pop);
    drop     = pushing & ~bypass & full & ~pop;

    tap_n        = tap;
    push_valid_n = vin;
    push_data_n  = push_data;
    if (vin) begin
      tap_n[0]    = DIN_SRC;
      tap_n[1]    = tap[0];
      tap_n[2]    = tap[1];
      tap_n[3]    = tap[2];
      push_data_n = y;
    end else begin
      tap_n       = tap;
    end

    wr_ptr_n = wr_en ? (wr_ptr + PTR_ONE) : wr_ptr;
    rd_ptr_n = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
    if (wr_en && !pop) begin
      count_n = count + CNT_ONE;
    end else if (pop && !wr_en) begin
      count_n = count - CNT_ONE;
    end else begin
      count_n = count;
    end

    err_n = mismatch;
    if (mismatch && (ERR_CNT != 16'hFFFF)) begin
      err_cnt_n = ERR_CNT + 16'd1;
    end else begin
      err_cnt_n = ERR_CNT;
    end
    if (matched && (MATCH_CNT != 16'hFFFF)) begin
      match_cnt_n = MATCH_CNT + 16'd1;
    end else begin
      match_cnt_n = MATCH_CNT;
    end
    ovf_n = OVF | drop;
    unf_n = UNF | (vout & empty & ~pushing);

    // Stall timer counts cycles with work outstanding and no DUT output.
    if (!active) begin
      timer_n = timer;
    end else if (vout || empty) begin
      timer_n = {TW{1'b0}};
    end else if (timer != T_MAX) begin
      timer_n = timer + T_ONE;
    end else begin
      timer_n = timer;
    end
    stall_n = STALL | (active & ~vout & ~empty & (timer == T_LAST));

    exit_drain = (empty & ~push_valid & ~VIN_SRC) | STALL;
    done_n     = DONE;
    case (state)
      ST_RUN: begin
        if (END_SIM) state_n = ST_DRAIN;
        else         state_n = ST_RUN;
      end
      ST_DRAIN: begin
        if (exit_drain) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_DONE:  state_n = ST_DONE;
      default:  state_n = ST_RUN;
    endcase
    pass_n = done_n & (err_cnt_n == 16'h0000) & ~ovf_n & ~unf_n & ~stall_n;
  end

  // Register all state and outputs; reset discards queue and verdicts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < 4; k++) tap[k] <= {NB{1'b0}};
      push_valid <= 1'b0;
      push_data  <= {NB{1'b0}};
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      count      <= {CW{1'b0}};
      timer      <= {TW{1'b0}};
      state      <= ST_RUN;
      ERR        <= 1'b0;
      ERR_CNT    <= 16'h0000;
      MATCH_CNT  <= 16'h0000;
      OVF        <= 1'b0;
      UNF        <= 1'b0;
      STALL      <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
    end else begin
      tap        <= tap_n;
      push_valid <= push_valid_n;
      push_data  <= push_data_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      count      <= count_n;
      timer      <= timer_n;
      state      <= state_n;
      ERR        <= err_n;
      ERR_CNT    <= err_cnt_n;
      MATCH_CNT  <= match_cnt_n;
      OVF        <= ovf_n;
      UNF        <= unf_n;
      STALL      <= stall_n;
      DONE       <= done_n;
      PASS       <= pass_n;
    end
  end

  // Expected-value storage; stale contents are harmless since pointers reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end
endmodule

// File: tb/tb_fir_out_checker.sv
module tb_fir_out_checker;
  localparam int NB = 9;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          VIN_SRC = 1'b0;
  logic [NB-1:0] DIN_SRC = '0;
  logic [NB-1:0] B0 = '0, B1 = '0, B2 = '0, B3 = '0, B4 = '0;
  logic          VOUT_DUT = 1'b0;
  logic [NB-1:0] DOUT_DUT = '0;
  logic          END_SIM = 1'b0;
  logic          ERR;
  logic [15:0]   ERR_CNT, MATCH_CNT;
  logic          OVF, UNF, STALL, DONE, PASS;

  fir_out_checker #(.NB(NB), .FIFO_DEPTH(16), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST), .VIN_SRC(VIN_SRC), .DIN_SRC(DIN_SRC),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .VOUT_DUT(VOUT_DUT), .DOUT_DUT(DOUT_DUT), .END_SIM(END_SIM),
    .ERR(ERR), .ERR_CNT(ERR_CNT), .MATCH_CNT(MATCH_CNT),
    .OVF(OVF), .UNF(UNF), .STALL(STALL), .DONE(DONE), .PASS(PASS)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  // Reference model: coefficients, sample history, golden queue with ready cycle.
  int bq[5];
  int hist[4];
  int gold_val[$];
  int gold_rdy[$];
  // Emulated FIR under test: scheduled outputs.
  int emit_val[$];
  int emit_due[$];
  // Scoreboard of expected ERR per presented DUT output.
  bit err_q[$];
  int m_match, m_err;
  bit m_unf;
  int cyc = 0;
  int lat = 3;
  bit silent = 1'b0;
  int corrupt_idx = -1;
  int n_issued = 0;
  bit sb_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sx(input logic [NB-1:0] v);
    return int'($signed(v));
  endfunction

  // y = floor(sum(bk*xk) / 2^(NB-1)) reduced modulo 2^NB.
  function automatic int golden(input int din);
    int acc;
    acc = bq[0] * din + bq[1] * hist[0] + bq[2] * hist[1] + bq[3] * hist[2] + bq[4] * hist[3];
    return (acc >>> (NB - 1)) & ((1 << NB) - 1);
  endfunction

  task automatic set_coef(input bit rnd, input logic [NB-1:0] c);
    logic [NB-1:0] v[5];
    for (int k = 0; k < 5; k++) begin
      v[k] = rnd ? NB'($urandom) : c;
      bq[k] = sx(v[k]);
    end
    B0 = v[0]; B1 = v[1]; B2 = v[2]; B3 = v[3]; B4 = v[4];
  endtask

  // One clock of stimulus: sample in, emulated DUT output, model update.
  task automatic tick(input bit vin, input logic [NB-1:0] din, input bit fv, input logic [NB-1:0] fval);
    int y, g, tmp;
    bit e;
    VIN_SRC = vin;
    DIN_SRC = vin ? din : '0;
    if (vin) begin
      y = golden(sx(din));
      for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sx(din);
      gold_val.push_back(y);
      gold_rdy.push_back(cyc + 1);
      if (!silent) begin
        emit_val.push_back((n_issued == corrupt_idx) ? (y ^ 1) : y);
        emit_due.push_back(cyc + lat);
      end
      n_issued++;
    end
    VOUT_DUT = 1'b0;
    DOUT_DUT = '0;
    if (fv) begin
      VOUT_DUT = 1'b1;
      DOUT_DUT = fval;
    end else if (emit_due.size() > 0 && emit_due[0] <= cyc) begin
      tmp = emit_val.pop_front();
      void'(emit_due.pop_front());
      VOUT_DUT = 1'b1;
      DOUT_DUT = tmp[NB-1:0];
    end
    if (VOUT_DUT) begin
      if (gold_rdy.size() > 0 && gold_rdy[0] <= cyc) begin
        g = gold_val.pop_front();
        void'(gold_rdy.pop_front());
        e = (int'(DOUT_DUT) != g);
        if (e) m_err++;
        else   m_match++;
      end else begin
        e = 1'b0;
        m_unf = 1'b1;
      end
      if (sb_en) err_q.push_back(e);
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    RST = 1'b1; VIN_SRC = 1'b0; DIN_SRC = '0; VOUT_DUT = 1'b0; DOUT_DUT = '0; END_SIM = 1'b0;
    @(posedge CLK);
    #1;
    cyc++;
    RST = 1'b0;
    for (int k = 0; k < 4; k++) hist[k] = 0;
    gold_val.delete(); gold_rdy.delete(); emit_val.delete(); emit_due.delete(); err_q.delete();
    m_match = 0; m_err = 0; m_unf = 1'b0; n_issued = 0; corrupt_idx = -1; silent = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_err"}, ERR, 0);
    check({tag, "_err_cnt"}, ERR_CNT, 0);
    check({tag, "_match_cnt"}, MATCH_CNT, 0);
    check({tag, "_ovf"}, OVF, 0);
    check({tag, "_unf"}, UNF, 0);
    check({tag, "_stall"}, STALL, 0);
    check({tag, "_done"}, DONE, 0);
    check({tag, "_pass"}, PASS, 0);
  endtask

  task automatic run(input int n, input int l, input int cidx, input bit sil, input bit dense);
    lat = l; corrupt_idx = cidx; silent = sil;
    for (int i = 0; i < n; i++) begin
      if (dense || $urandom_range(0, 3) != 0) tick(1'b1, NB'($urandom), 1'b0, '0);
      else tick(1'b0, '0, 1'b0, '0);
    end
  endtask

  task automatic finish_run(input string tag, input bit exp_pass);
    int n = 0;
    END_SIM = 1'b1;
    while (DONE !== 1'b1 && n < 400) begin
      tick(1'b0, '0, 1'b0, '0);
      n++;
    end
    check({tag, "_done"}, DONE, 1);
    check({tag, "_pass"}, PASS, exp_pass);
    if (sb_en) begin
      check({tag, "_err_cnt"}, ERR_CNT, m_err);
      check({tag, "_match_cnt"}, MATCH_CNT, m_match);
      check({tag, "_unf"}, UNF, m_unf);
    end
  endtask

  // Monitor: every presented DUT output yields one ERR response a cycle later.
  initial begin
    bit seen, exp_err;
    forever begin
      @(posedge CLK);
      seen = (VOUT_DUT === 1'b1) && sb_en && (RST === 1'b0);
      @(negedge CLK);
      if (sb_en) begin
        if (seen && err_q.size() > 0) exp_err = err_q.pop_front();
        else exp_err = 1'b0;
        check("err_pulse", ERR, exp_err);
        if (DONE !== 1'b1) check("pass_without_done", PASS, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    set_coef(1'b0, 9'h040);
    do_reset();
    sb_en = 1'b1;
    check_idle("reset");

    // Impulse with 9'h0FF then zeros, correct echo.
    lat = 3;
    for (int i = 0; i < 8; i++) tick(1'b1, (i == 0) ? 9'h0FF : 9'h000, 1'b0, '0);
    finish_run("impulse", 1'b1);
    check("impulse_matches", MATCH_CNT, 8);

    // Third DUT output corrupted in bit 0.
    set_coef(1'b1, '0);
    do_reset();
    run(16, 4, 2, 1'b0, 1'b1);
    finish_run("corrupt", 1'b0);
    check("corrupt_one_err", ERR_CNT, 1);
    check("corrupt_matches", MATCH_CNT, 15);

    // 20 back-to-back samples, latency 18: queue overflows.
    sb_en = 1'b0;
    do_reset();
    run(20, 18, -1, 1'b0, 1'b1);
    finish_run("ovf18", 1'b0);
    check("ovf18_flag", OVF, 1);
    do_reset();
    sb_en = 1'b1;

    // Same with latency 3: no overflow.
    run(20, 3, -1, 1'b0, 1'b1);
    finish_run("lat3", 1'b1);
    check("lat3_ovf", OVF, 0);
    check("lat3_matches", MATCH_CNT, 20);

    // Output before any sample: underflow, no counter change.
    do_reset();
    tick(1'b0, '0, 1'b1, NB'($urandom));
    tick(1'b0, '0, 1'b0, '0);
    check("unf_flag", UNF, 1);
    check("unf_err_cnt", ERR_CNT, 0);
    check("unf_match_cnt", MATCH_CNT, 0);

    // Latency 1: every compare uses the bypass path.
    do_reset();
    run(6, 1, -1, 1'b0, 1'b1);
    finish_run("bypass", 1'b1);
    check("bypass_unf", UNF, 0);
    check("bypass_matches", MATCH_CNT, 6);

    // Four outputs queued, DUT silent: stall, then DONE with PASS low.
    do_reset();
    run(4, 1, -1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b0, '0, 1'b0, '0);
    check("stall_early", STALL, 0);
    finish_run("stall", 1'b0);
    check("stall_flag", STALL, 1);

    // Mid-stream reset, then a fresh run with gaps and random latency.
    set_coef(1'b1, '0);
    do_reset();
    run(8, 3, 2, 1'b0, 1'b1);
    do_reset();
    check_idle("midrst");
    run(12, int'($urandom_range(1, 6)), -1, 1'b0, 1'b0);
    finish_run("fresh", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
